// File: rtl/muldiv_sequencer_pkg.sv
// Shared types and decode constants for the multiply/divide sequencer.
package muldiv_sequencer_pkg;

  // Sequencer state; MUL/DIV are the iterating states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  // R-type funct codes shared with the control unit decode.
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

endpackage

// File: rtl/muldiv_sequencer_step.sv
// One radix-2 iteration of unsigned shift-add multiply or restoring divide.
// acc_i/acc_o hold {upper, lower}: {product_hi, product_lo} or {R, Q}.
// in_bit is the current multiplier bit (MUL) or next dividend bit (DIV).
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 mode_div,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     operand,
  input  logic                 in_bit,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] rem_shift;
  logic [WIDTH-1:0] rem_sub;
  logic             rem_ge;

  // Single combinational step; the divide trial subtract is expressed as a
  // WIDTH+1-bit compare plus a WIDTH-bit subtract (the kept difference always
  // fits in WIDTH bits), which gives the same result as a signed trial.
  always_comb begin
    sum       = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (in_bit ? {1'b0, operand} : '0);
    rem_shift = {acc_i[2*WIDTH-2:WIDTH], in_bit};
    rem_ge    = {acc_i[2*WIDTH-1:WIDTH], in_bit} >= {1'b0, operand};
    rem_sub   = rem_shift - operand;
    if (!mode_div) begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end else if (rem_ge) begin
      acc_o = {rem_sub, acc_i[WIDTH-2:0], 1'b1};
    end else begin
      acc_o = {rem_shift, acc_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULTU/DIVU sequencer with HI/LO registers and pipeline interlock.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_mul,
  input  logic             start_div,
  input  logic             rd_hilo,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  muldiv_state_t      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_next;
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand (MUL) or divisor (DIV)
  logic [WIDTH-1:0]   strm_q, strm_d;   // multiplier (MUL) or dividend (DIV), shifted out bit by bit
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;
  logic               mode_div;
  logic               in_bit;
  logic               last_iter;

  assign mode_div  = (state_q == DIV);
  assign in_bit    = mode_div ? strm_q[WIDTH-1] : strm_q[0];
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .mode_div(mode_div),
    .acc_i   (acc_q),
    .operand (opnd_q),
    .in_bit  (in_bit),
    .acc_o   (acc_next)
  );

  // Next-state, iteration and commit logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    strm_d     = strm_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (start_mul) begin
          state_d = MUL;
          opnd_d  = op_a;
          strm_d  = op_b;
          cnt_d   = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
        end else if (start_div) begin
          state_d = DIV;
          opnd_d  = op_b;
          strm_d  = op_a;
          cnt_d   = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
        end
      end
      MUL, DIV: begin
        if (flush) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          acc_d  = acc_next;
          cnt_d  = cnt_q + CNT_W'(1);
          strm_d = mode_div ? {strm_q[WIDTH-2:0], 1'b0} : {1'b0, strm_q[WIDTH-1:1]};
          if (last_iter) begin
            state_d    = DONE;
            busy_d     = 1'b0;
            cnt_d      = '0;
            done_d     = 1'b1;
            div_zero_d = mode_div && (opnd_q == '0);
            hi_d       = acc_next[2*WIDTH-1:WIDTH];
            lo_d       = acc_next[WIDTH-1:0];
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      strm_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      strm_q     <= strm_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign stall    = busy_q & (rd_hilo | start_mul | start_div);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected HI/LO/div_zero are queued at
// issue and checked when done pulses.
module tb_muldiv_sequencer;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_mul, start_div, rd_hilo, flush;
  logic [31:0] op_a, op_b;
  logic        busy, stall, done, div_zero;
  logic [31:0] hi, lo;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_mul(start_mul),
    .start_div(start_div),
    .rd_hilo  (rd_hilo),
    .flush    (flush),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  // Drive an issue at the current negedge; optionally queue the expected result.
  task automatic issue(input logic mul, input logic div, input logic [31:0] a,
                       input logic [31:0] b, input logic expect_result);
    exp_t        e;
    logic [63:0] p;
    start_mul = mul;
    start_div = div;
    op_a      = a;
    op_b      = b;
    if (mul) begin
      p    = {32'd0, a} * {32'd0, b};
      e.hi = p[63:32];
      e.lo = p[31:0];
      e.dz = 1'b0;
    end else if (b == 32'd0) begin
      e.hi = a;
      e.lo = 32'hFFFF_FFFF;
      e.dz = 1'b1;
    end else begin
      e.hi = a % b;
      e.lo = a / b;
      e.dz = 1'b0;
    end
    if (expect_result) exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start_mul = 1'b0;
    start_div = 1'b0;
    op_a      = $urandom;
    op_b      = $urandom;
  endtask

  // Advance from cycle 1 until done is seen or the budget expires.
  task automatic run_to_done(output int cycles);
    cycles = 1;
    while (!done && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset;
    rd_hilo = 1'b1;
    @(negedge clk);
    vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL reset_hi got %h exp 0", hi); end
    vectors++; if (lo !== 32'd0) begin miscompares++; $display("FAIL reset_lo got %h exp 0", lo); end
    vectors++; if ({busy, done, div_zero, stall} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_flags got %b exp 0000", {busy, done, div_zero, stall});
    end
    rd_hilo = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul_max;
    int   cyc;
    exp_t e;
    issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mul_busy got %b exp 1", busy); end
    run_to_done(cyc);
    e = exp_q.pop_front();
    vectors++; if (cyc !== 33) begin miscompares++; $display("FAIL mul_latency got %0d exp 33", cyc); end
    vectors++; if (hi !== 32'hFFFF_FFFE || hi !== e.hi) begin miscompares++; $display("FAIL mul_hi got %h exp %h", hi, e.hi); end
    vectors++; if (lo !== 32'h0000_0001 || lo !== e.lo) begin miscompares++; $display("FAIL mul_lo got %h exp %h", lo, e.lo); end
    vectors++; if ({busy, div_zero} !== 2'b00) begin miscompares++; $display("FAIL mul_done_flags got %b exp 00", {busy, div_zero}); end
    @(negedge clk);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL mul_done_pulse got %b exp 0", done); end
  endtask

  task automatic test_back_to_back;
    int   cyc;
    exp_t e;
    issue(1'b0, 1'b1, 32'd100, 32'd7, 1'b1);
    run_to_done(cyc);
    e = exp_q.pop_front();
    vectors++; if ({hi, lo} !== {e.hi, e.lo} || lo !== 32'd14 || hi !== 32'd2) begin
      miscompares++; $display("FAIL div_100_7 got %h/%h exp %h/%h", hi, lo, e.hi, e.lo);
    end
    // Issue in the DONE cycle itself.
    issue(1'b1, 1'b0, 32'd3, 32'd5, 1'b1);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept got busy %b exp 1", busy); end
    run_to_done(cyc);
    e = exp_q.pop_front();
    vectors++; if (cyc !== 33) begin miscompares++; $display("FAIL b2b_latency got %0d exp 33", cyc); end
    vectors++; if ({hi, lo} !== {e.hi, e.lo} || lo !== 32'd15) begin
      miscompares++; $display("FAIL b2b_mul got %h/%h exp %h/%h", hi, lo, e.hi, e.lo);
    end
    @(negedge clk);
  endtask

  task automatic test_div_zero;
    int   cyc;
    exp_t e;
    issue(1'b0, 1'b1, 32'h1234_5678, 32'd0, 1'b1);
    run_to_done(cyc);
    e = exp_q.pop_front();
    vectors++; if ({hi, lo} !== {e.hi, e.lo} || hi !== 32'h1234_5678) begin
      miscompares++; $display("FAIL divz_result got %h/%h exp %h/%h", hi, lo, e.hi, e.lo);
    end
    vectors++; if ({done, div_zero} !== {1'b1, e.dz}) begin
      miscompares++; $display("FAIL divz_flag got %b exp %b", {done, div_zero}, {1'b1, e.dz});
    end
    @(negedge clk);
    vectors++; if (div_zero !== 1'b0) begin miscompares++; $display("FAIL divz_pulse got %b exp 0", div_zero); end
  endtask

  task automatic test_stall;
    int   cyc;
    int   stall_cnt;
    exp_t e;
    issue(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0001_2345, 1'b1);
    rd_hilo   = 1'b1;
    stall_cnt = 0;
    cyc       = 1;
    while (!done && cyc < 40) begin
      if (stall) stall_cnt++;
      @(negedge clk);
      cyc++;
    end
    e = exp_q.pop_front();
    vectors++; if (stall_cnt !== 32) begin miscompares++; $display("FAIL stall_cycles got %0d exp 32", stall_cnt); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL stall_in_done got %b exp 0", stall); end
    vectors++; if ({hi, lo} !== {e.hi, e.lo}) begin
      miscompares++; $display("FAIL stall_read got %h/%h exp %h/%h", hi, lo, e.hi, e.lo);
    end
    @(negedge clk);
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL stall_in_idle got %b exp 0", stall); end
    rd_hilo = 1'b0;
  endtask

  task automatic test_flush;
    int   cyc;
    int   done_cnt;
    exp_t e;
    issue(1'b0, 1'b1, 32'h0000_00BA, 32'h0000_0010, 1'b1);
    run_to_done(cyc);
    e = exp_q.pop_front();
    vectors++; if ({hi, lo} !== {e.hi, e.lo} || hi !== 32'hA || lo !== 32'hB) begin
      miscompares++; $display("FAIL flush_setup got %h/%h exp %h/%h", hi, lo, e.hi, e.lo);
    end
    @(negedge clk);
    issue(1'b0, 1'b1, 32'hCAFE_F00D, 32'h0000_0123, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_busy got %b exp 0", busy); end
    done_cnt = 0;
    repeat (40) begin
      if (done || div_zero) done_cnt++;
      @(negedge clk);
    end
    vectors++; if (done_cnt !== 0) begin miscompares++; $display("FAIL flush_done got %0d pulses exp 0", done_cnt); end
    vectors++; if (hi !== 32'hA || lo !== 32'hB) begin
      miscompares++; $display("FAIL flush_hilo got %h/%h exp 0000000a/0000000b", hi, lo);
    end
  endtask

  task automatic test_reset_mid;
    int done_cnt;
    issue(1'b1, 1'b0, 32'h0BAD_F00D, 32'h7777_1111, 1'b0);
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++; if ({hi, lo} !== 64'd0) begin miscompares++; $display("FAIL rst_mid_hilo got %h/%h exp 0/0", hi, lo); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (40) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    vectors++; if (done_cnt !== 0) begin miscompares++; $display("FAIL rst_mid_done got %0d pulses exp 0", done_cnt); end
  endtask

  task automatic test_both_starts;
    int   cyc;
    exp_t e;
    issue(1'b1, 1'b1, 32'd1234, 32'd56, 1'b1);
    run_to_done(cyc);
    e = exp_q.pop_front();
    vectors++; if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz} || lo !== 32'd69104) begin
      miscompares++; $display("FAIL both_starts got %h/%h exp %h/%h", hi, lo, e.hi, e.lo);
    end
    @(negedge clk);
    vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL scoreboard_left got %0d exp 0", exp_q.size()); end
  endtask

  initial begin
    rst_n     = 1'b0;
    start_mul = 1'b0;
    start_div = 1'b0;
    rd_hilo   = 1'b0;
    flush     = 1'b0;
    op_a      = '0;
    op_b      = '0;
    test_reset();
    test_mul_max();
    test_back_to_back();
    test_div_zero();
    test_stall();
    test_flush();
    test_reset_mid();
    test_both_starts();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
